// File: rtl/button_toggle_conditioner_if.sv
// Push-button conditioner bus: raw button in, T pulse / level / press count out.
interface button_toggle_conditioner_if;
   logic       input_push_button3_btn_3;
   logic       output_led1_t_0_4;
   logic       output_led2_level_0_5;
   logic [3:0] output_led3_count_0_6;

   // Button source / LED consumer side
   modport master (
      output input_push_button3_btn_3,
      input  output_led1_t_0_4,
      input  output_led2_level_0_5,
      input  output_led3_count_0_6
   );

   // Conditioner side
   modport slave (
      input  input_push_button3_btn_3,
      output output_led1_t_0_4,
      output output_led2_level_0_5,
      output output_led3_count_0_6
   );
endinterface

// File: rtl/button_toggle_conditioner.sv
// Synchronises and debounces a raw push-button, emitting one registered
// single-cycle T pulse per accepted press plus debounced level and a
// wrapping 4-bit press count.
module button_toggle_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_WIDTH       = 8
) (
   input  logic                          input_clock1_clk_1,
   input  logic                          input_input_switch2_reset_2,
   button_toggle_conditioner_if.slave    bus
);

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      PRESS_WAIT   = 2'd1,
      HELD         = 2'd2,
      RELEASE_WAIT = 2'd3
   } state_e;

   // Counter compare is done one bit wider so cnt+1 never wraps.
   localparam logic [CNT_WIDTH:0] DB_LIM = (CNT_WIDTH + 1)'(DEBOUNCE_CYCLES);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   logic                 sync1_q, bs_q;
   state_e               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 t_q, t_d;
   logic                 level_q, level_d;
   logic [3:0]           count_q, count_d;
   logic                 commit;

   assign commit = ({1'b0, cnt_q} + 1'b1) >= DB_LIM;

   // Two-flop synchroniser for the asynchronous button.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values; blocking here would collapse the two stages into one.
   always_ff @(posedge input_clock1_clk_1 or posedge input_input_switch2_reset_2) begin
      if (input_input_switch2_reset_2) begin
         sync1_q <= 1'b0;
         bs_q    <= 1'b0;
      end else begin
         sync1_q <= bus.input_push_button3_btn_3;
         bs_q    <= sync1_q;
      end
   end

   // State, debounce counter and registered outputs.
   always_ff @(posedge input_clock1_clk_1 or posedge input_input_switch2_reset_2) begin
      if (input_input_switch2_reset_2) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         t_q     <= 1'b0;
         level_q <= 1'b0;
         count_q <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         t_q     <= t_d;
         level_q <= level_d;
         count_q <= count_d;
      end
   end

   // Next-state, counter and output decode for the debounce FSM.
   always_comb begin
      // NOTE: every target gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_d = state_q;
      cnt_d   = '0;
      t_d     = 1'b0;
      level_d = level_q;
      count_d = count_q;

      unique case (state_q)
         IDLE: begin
            if (bs_q) begin
               if (DEBOUNCE_CYCLES <= 1) begin
                  state_d = HELD;
                  level_d = 1'b1;
                  t_d     = 1'b1;
                  count_d = count_q + 4'd1;
               end else begin
                  state_d = PRESS_WAIT;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         PRESS_WAIT: begin
            if (!bs_q) begin
               state_d = IDLE;
            end else if (commit) begin
               state_d = HELD;
               level_d = 1'b1;
               t_d     = 1'b1;
               count_d = count_q + 4'd1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         HELD: begin
            if (!bs_q) begin
               if (DEBOUNCE_CYCLES <= 1) begin
                  state_d = IDLE;
                  level_d = 1'b0;
               end else begin
                  state_d = RELEASE_WAIT;
                  cnt_d   = CNT_ONE;
               end
            end
         end
         RELEASE_WAIT: begin
            if (bs_q) begin
               state_d = HELD;
            end else if (commit) begin
               state_d = IDLE;
               level_d = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.output_led1_t_0_4     = t_q;
   assign bus.output_led2_level_0_5 = level_q;
   assign bus.output_led3_count_0_6 = count_q;

endmodule

// File: tb/tb_button_toggle_conditioner.sv
// Directed bench for button_toggle_conditioner (DEBOUNCE_CYCLES = 4) with a
// downstream T flip-flop model.
module tb_button_toggle_conditioner;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tff_clr = 1'b1;
   logic tff_q, tff_qn;
   int   total = 0;
   int   bad   = 0;

   button_toggle_conditioner_if bif ();

   button_toggle_conditioner #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(8)) dut (
      .input_clock1_clk_1          (clk),
      .input_input_switch2_reset_2 (rst),
      .bus                         (bif.slave)
   );

   always #5 clk = ~clk;

   // Downstream T flip-flop (preset/clear inactive), Q starts at 0.
   always_ff @(posedge clk) begin
      if (tff_clr) begin
         tff_q  <= 1'b0;
         tff_qn <= 1'b1;
      end else if (bif.output_led1_t_0_4) begin
         tff_q  <= ~tff_q;
         tff_qn <= ~tff_qn;
      end
   end

   task automatic check(input string tag, input int got, input int exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0d expected=%0d @%0t", tag, got, exp, $time);
      end
   endtask

   // Advance one rising edge, then settle 1ns past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   // Hold btn high for `hold` cycles then low for `low` cycles; count pulses.
   task automatic press(input int hold, input int low, output int pulses);
      pulses = 0;
      bif.input_push_button3_btn_3 = 1'b1;
      for (int i = 0; i < hold; i++) begin
         tick();
         if (bif.output_led1_t_0_4) pulses++;
      end
      bif.input_push_button3_btn_3 = 1'b0;
      for (int i = 0; i < low; i++) begin
         tick();
         if (bif.output_led1_t_0_4) pulses++;
      end
   endtask

   initial begin
      int pulses;
      int lvl_bad;
      int t_bad;
      logic [6:0] bounce;
      bif.input_push_button3_btn_3 = 1'b0;

      // Reset state without any clock edge yet.
      #1;
      check("rst_t", bif.output_led1_t_0_4, 0);
      check("rst_level", bif.output_led2_level_0_5, 0);
      check("rst_count", bif.output_led3_count_0_6, 0);
      repeat (2) tick();
      rst = 1'b0;
      tick();

      // Clean press: pulse only after e5, level from e5.
      t_bad = 0; lvl_bad = 0;
      bif.input_push_button3_btn_3 = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (bif.output_led1_t_0_4 !== (i == 5)) t_bad++;
         if (bif.output_led2_level_0_5 !== (i >= 5)) lvl_bad++;
      end
      check("press_t_window", t_bad, 0);
      check("press_level", lvl_bad, 0);
      check("press_count", bif.output_led3_count_0_6, 1);
      // Release: level falls after the fifth edge following first low sample.
      t_bad = 0; lvl_bad = 0;
      bif.input_push_button3_btn_3 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bif.output_led1_t_0_4 !== 1'b0) t_bad++;
         if (bif.output_led2_level_0_5 !== (i < 5)) lvl_bad++;
      end
      check("release_no_pulse", t_bad, 0);
      check("release_level", lvl_bad, 0);
      check("release_count", bif.output_led3_count_0_6, 1);

      // Bounce rejection.
      do_reset();
      check("bounce_pre_count", bif.output_led3_count_0_6, 0);
      bounce = 7'b0111011;  // applied LSB first: 1,1,0,1,1,1,0
      t_bad = 0; lvl_bad = 0;
      for (int i = 0; i < 17; i++) begin
         bif.input_push_button3_btn_3 = (i < 7) ? bounce[i] : 1'b0;
         tick();
         if (bif.output_led1_t_0_4 !== 1'b0) t_bad++;
         if (bif.output_led2_level_0_5 !== 1'b0) lvl_bad++;
      end
      check("bounce_no_pulse", t_bad, 0);
      check("bounce_level", lvl_bad, 0);
      check("bounce_count", bif.output_led3_count_0_6, 0);

      // Release bounce while held.
      press(10, 0, pulses);
      check("held_pulses", pulses, 1);
      t_bad = 0; lvl_bad = 0;
      for (int i = 0; i < 14; i++) begin
         bif.input_push_button3_btn_3 = (i < 2) ? 1'b0 : 1'b1;
         tick();
         if (bif.output_led1_t_0_4 !== 1'b0) t_bad++;
         if (bif.output_led2_level_0_5 !== 1'b1) lvl_bad++;
      end
      check("relbounce_no_pulse", t_bad, 0);
      check("relbounce_level", lvl_bad, 0);
      check("relbounce_count", bif.output_led3_count_0_6, 1);
      press(0, 12, pulses);
      check("relbounce_final_level", bif.output_led2_level_0_5, 0);

      // Wrap: 17 presses, one pulse each, count modulo 16.
      do_reset();
      for (int k = 1; k <= 17; k++) begin
         press(8, 12, pulses);
         check($sformatf("wrap_pulses_%0d", k), pulses, 1);
         if (k >= 15) check($sformatf("wrap_count_%0d", k), bif.output_led3_count_0_6, k % 16);
      end

      // Async reset mid-debounce (PRESS_WAIT, cnt=2 after e3).
      check("pre_async_count", bif.output_led3_count_0_6, 1);
      bif.input_push_button3_btn_3 = 1'b1;
      repeat (4) tick();
      #2 rst = 1'b1;
      #1;
      check("async_t", bif.output_led1_t_0_4, 0);
      check("async_level", bif.output_led2_level_0_5, 0);
      check("async_count", bif.output_led3_count_0_6, 0);
      t_bad = 0;
      repeat (3) begin
         tick();
         if (bif.output_led1_t_0_4 !== 1'b0) t_bad++;
      end
      check("in_reset_no_pulse", t_bad, 0);
      rst = 1'b0;
      t_bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (bif.output_led1_t_0_4 !== (i == 5)) t_bad++;
      end
      check("post_reset_pulse_window", t_bad, 0);
      check("post_reset_count", bif.output_led3_count_0_6, 1);
      press(0, 12, pulses);

      // Chained with the T flip-flop: Q sequence 1, 0, 1.
      do_reset();
      tff_clr = 1'b0;
      for (int k = 0; k < 3; k++) begin
         press(8, 12, pulses);
         check($sformatf("tff_q_%0d", k), tff_q, (k % 2 == 0) ? 1 : 0);
         check($sformatf("tff_qn_%0d", k), tff_qn, (k % 2 == 0) ? 0 : 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Safety bound so the run always terminates.
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time bound");
      $fatal(1);
   end

endmodule

// File: doc/button_toggle_conditioner.md
# button_toggle_conditioner

Conditions a raw push-button into a clean single-cycle toggle request for the T flip-flop stage directly downstream. It synchronises the asynchronous button to the clock domain, debounces it with a consecutive-sample counter, and emits exactly one T pulse per accepted press. It also reports the debounced level and a wrapping press count for LED display.

## Interface
- DEBOUNCE_CYCLES, 4, consecutive identical synchronised samples required to accept a level change; legal range 1..255
- CNT_WIDTH, 8, width of internal debounce counter; must hold DEBOUNCE_CYCLES
- input_clock1_clk_1  in  1  single clock, all state on rising edge
- input_input_switch2_reset_2  in  1  asynchronous, active-high reset
- input_push_button3_btn_3  in  1  raw button, asynchronous, may bounce; 1 = pressed
- output_led1_t_0_4  out  1  T pulse to the flip-flop stage; high for exactly one cycle per accepted press
- output_led2_level_0_5  out  1  debounced button level
- output_led3_count_0_6  out  4  accepted-press count, modulo 16

## Operation
- Synchroniser: two flops, sync1 <= btn, bs <= sync1; reset to 0. Only bs is used downstream of them.
- FSM states:
  - IDLE: stable level 0
  - PRESS_WAIT: candidate level 1
  - HELD: stable level 1
  - RELEASE_WAIT: candidate level 0
- Debounce counter cnt: cleared on every state entry other than the WAIT states.
- IDLE: bs=1 -> PRESS_WAIT, cnt=1; else stay, cnt=0.
- PRESS_WAIT:
  - bs=0 (bounce) -> IDLE, cnt=0, no pulse.
  - bs=1 and cnt+1 < DEBOUNCE_CYCLES -> cnt++.
  - bs=1 and cnt+1 >= DEBOUNCE_CYCLES -> HELD, level=1, pulse=1, count++.
  - DEBOUNCE_CYCLES=1: the IDLE sample alone commits (IDLE -> HELD directly).
- HELD: bs=0 -> RELEASE_WAIT, cnt=1; else stay. Pulse is 0 in HELD regardless of hold duration.
- RELEASE_WAIT:
  - bs=1 -> HELD, cnt=0, no pulse.
  - bs=0 and cnt+1 >= DEBOUNCE_CYCLES -> IDLE, level=0.
  - otherwise cnt++.
- Release never generates a pulse and never changes count.
- Count is 4-bit and wraps 15 -> 0 on the 16th press; no saturation.
- All outputs are registered; no combinational path from any input to any output.

## Timing
- Reset (async assert, any time): state=IDLE, cnt=0, sync1=bs=0, output_led1_t_0_4=0, output_led2_level_0_5=0, output_led3_count_0_6=0. Takes effect without a clock edge.
- Reset mid-operation: any in-progress debounce is discarded and no pulse is emitted during reset.
- Button held through reset release: treated as a new press; pulse follows the normal latency measured from the first edge after release.
- Press latency: btn goes high and stays high, first sampled at edge e0.
  - bs=1 after e1.
  - Samples at e2..e(1+N) are counted, where N = DEBOUNCE_CYCLES.
  - Pulse and level rise after edge e(1+N).
  - Pulse falls after edge e(2+N).
  - N=4: pulse is high between edges e5 and e6.
- Release latency: level falls N+1 edges after the first low sample, symmetric to press.
- Bounce shorter than N consecutive samples in either WAIT state is fully rejected.
- Minimum press-to-press interval for distinct pulses: 2N+2 cycles. Consecutive pulses are therefore separated by at least one low cycle, so the downstream T flip-flop toggles exactly once per press.

## Test plan
- Clean press, N=4: reset 2 cycles, btn=1 sampled at e0 and held 20 cycles -> pulse high only between e5 and e6; level=1 from e5; count=1; release -> level=0 five edges after first low sample; count stays 1.
- Bounce rejection: btn pattern 1,1,0,1,1,1,0 (one sample per cycle) then 0 -> pulse never asserts, level stays 0, count=0.
- Release bounce while held: in HELD, drive btn 0 for 2 cycles then 1 -> level stays 1, no second pulse, count unchanged.
- Wrap: 17 clean presses separated by 12 low cycles -> 17 single-cycle pulses; count reads 15 after the 16th press minus one, 0 after the 16th, 1 after the 17th.
- Async reset mid-debounce: assert reset between edges while in PRESS_WAIT with cnt=2 -> all outputs 0 immediately with no clock edge; btn held through release -> exactly one pulse at e5 after release, count=1.
- Chained with the T flip-flop (preset=clear=1, Q=0): 3 clean presses -> Q sequence 1, 0, 1; Q and Q̄ complementary after every pulse.
